// File: rtl/jtframe_ddram_bram_pkg.sv
// rtl/jtframe_ddram_bram_pkg.sv - shared state encoding, status selectors and LFSR taps
package jtframe_ddram_bram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RDPF = 2'd1,
        ST_RDB  = 2'd2,
        ST_WRB  = 2'd3
    } ddr_state_t;

    localparam logic [7:0] ST_SEL_FLAGS = 8'd0;
    localparam logic [7:0] ST_SEL_COUNT = 8'd1;
    localparam logic [7:0] ST_SEL_ADDR  = 8'd2;

    // Fibonacci feedback masks (shift left, feedback into bit 0) for maximal-length sequences.
    function automatic logic [31:0] lfsr_taps(input int width);
        case (width)
            4:       lfsr_taps = 32'h0000_000C;
            5:       lfsr_taps = 32'h0000_0014;
            6:       lfsr_taps = 32'h0000_0030;
            7:       lfsr_taps = 32'h0000_0060;
            16:      lfsr_taps = 32'h0000_D008;
            32:      lfsr_taps = 32'h8020_0003;
            default: lfsr_taps = 32'h0000_00B8;
        endcase
    endfunction

endpackage

// File: rtl/jtframe_ddram_bram_mem.sv
// rtl/jtframe_ddram_bram_mem.sv - 2^AW x 64 dual-port BRAM, byte-enable write, registered read
module jtframe_ddram_bram_mem #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [63:0]   i_din,
    input  logic [7:0]    i_be,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [63:0]   o_q
);

    logic [63:0] r_mem [2**AW];
    logic [63:0] r_q;

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < 8; b++) begin
                if (i_be[b]) begin
                    r_mem[i_waddr][b*8 +: 8] <= i_din[b*8 +: 8];
                end
            end
        end
        if (i_re) begin
            r_q <= r_mem[i_raddr];
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/jtframe_ddram_bram.sv
// rtl/jtframe_ddram_bram.sv - BRAM-backed DDRAM burst responder; JTFRAME_DDR_STALL_EN adds random busy stalls
module jtframe_ddram_bram
    import jtframe_ddram_bram_pkg::*;
#(
    parameter int         AW   = 12,
    parameter logic [3:0] BASE = 4'd3,
    parameter int         STW  = 8
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ddram_busy,
    input  logic [7:0]  ddram_burstcnt,
    input  logic [28:0] ddram_addr,
    input  logic        ddram_rd,
    input  logic        ddram_we,
    input  logic [63:0] ddram_din,
    input  logic [7:0]  ddram_be,
    output logic [63:0] ddram_dout,
    output logic        ddram_dout_ready,
    input  logic [7:0]  st_addr,
    output logic [7:0]  st_dout
);

    ddr_state_t    r_state, w_state_nx;
    logic [AW-1:0] r_addr, w_addr_nx;
    logic [8:0]    r_cnt, w_cnt_nx;
    logic          r_hit, w_hit_nx;
    logic          r_err_cmd, r_err_win;
    logic          w_err_cmd_set, w_err_win_set;
    logic [7:0]    r_st, w_st_nx;

    logic          w_mem_we, w_mem_re;
    logic [AW-1:0] w_mem_waddr, w_mem_raddr;
    logic [63:0]   w_q, w_data;
    logic          w_busy, w_avail, w_deliver;

    logic          w_in_hit;
    logic [AW-1:0] w_in_idx;
    logic [8:0]    w_burst;
    logic          w_last;

    assign w_in_idx = ddram_addr[AW-1:0];
    assign w_in_hit = (ddram_addr[28:25] == BASE) && (ddram_addr[24:AW] == '0);
    assign w_burst  = (ddram_burstcnt == 8'd0) ? 9'd256 : {1'b0, ddram_burstcnt};
    assign w_last   = (r_cnt == 9'd1);

    jtframe_ddram_bram_mem #(.AW(AW)) u_mem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_waddr (w_mem_waddr),
        .i_din   (ddram_din),
        .i_be    (ddram_be),
        .i_re    (w_mem_re),
        .i_raddr (w_mem_raddr),
        .o_q     (w_q)
    );

`ifdef JTFRAME_DDR_STALL_EN
    localparam logic [31:0] LFSR_TAPS = lfsr_taps(STW);

    logic [STW-1:0] r_lfsr;
    logic           r_rd_pend;
    logic           r_skid_v;
    logic [63:0]    r_skid;

    assign w_busy  = r_lfsr[0];
    assign w_avail = r_skid_v || r_rd_pend;
    assign w_data  = r_skid_v ? r_skid : w_q;

    // A read issued while the initiator is stalled parks in the skid until busy drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr    <= {{(STW-1){1'b0}}, 1'b1};
            r_rd_pend <= 1'b0;
            r_skid_v  <= 1'b0;
            r_skid    <= '0;
        end else begin
            r_lfsr    <= {r_lfsr[STW-2:0], ^(r_lfsr & LFSR_TAPS[STW-1:0])};
            r_rd_pend <= w_mem_re;
            if (w_deliver) begin
                r_skid_v <= 1'b0;
            end else if (r_rd_pend) begin
                r_skid   <= w_q;
                r_skid_v <= 1'b1;
            end
        end
    end
`else
    logic [STW-1:0] w_unused_stw;

    assign w_unused_stw = '0;
    assign w_busy       = 1'b0;
    assign w_avail      = 1'b1;
    assign w_data       = w_q;
`endif

    always_comb begin
        w_state_nx    = r_state;
        w_addr_nx     = r_addr;
        w_cnt_nx      = r_cnt;
        w_hit_nx      = r_hit;
        w_err_cmd_set = 1'b0;
        w_err_win_set = 1'b0;
        w_mem_we      = 1'b0;
        w_mem_waddr   = r_addr;
        w_mem_re      = 1'b0;
        w_mem_raddr   = r_addr;
        w_deliver     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_busy && ddram_we) begin
                    w_err_cmd_set = ddram_rd;
                    w_err_win_set = !w_in_hit;
                    w_hit_nx      = w_in_hit;
                    w_mem_we      = w_in_hit;
                    w_mem_waddr   = w_in_idx;
                    w_addr_nx     = w_in_idx + AW'(1);
                    w_cnt_nx      = w_burst - 9'd1;
                    w_state_nx    = (w_burst == 9'd1) ? ST_IDLE : ST_WRB;
                end else if (!w_busy && ddram_rd) begin
                    w_err_win_set = !w_in_hit;
                    w_hit_nx      = w_in_hit;
                    w_addr_nx     = w_in_idx;
                    w_cnt_nx      = w_burst;
                    w_state_nx    = ST_RDPF;
                end
            end
            ST_RDPF: begin
                w_err_cmd_set = ddram_we;
                w_mem_re      = 1'b1;
                w_state_nx    = ST_RDB;
            end
            ST_RDB: begin
                // A rd overlapping the final beat is the chained-burst handoff, not an error.
                w_err_cmd_set = ddram_we || (ddram_rd && !w_last);
                if (!w_busy && w_avail) begin
                    w_deliver = 1'b1;
                    w_addr_nx = r_addr + AW'(1);
                    w_cnt_nx  = r_cnt - 9'd1;
                    if (w_last) begin
                        w_state_nx = ST_IDLE;
                    end else begin
                        w_mem_re    = 1'b1;
                        w_mem_raddr = r_addr + AW'(1);
                    end
                end
            end
            ST_WRB: begin
                w_err_cmd_set = ddram_rd && !w_last;
                if (!w_busy && ddram_we) begin
                    w_mem_we  = r_hit;
                    w_addr_nx = r_addr + AW'(1);
                    w_cnt_nx  = r_cnt - 9'd1;
                    if (w_last) begin
                        w_state_nx = ST_IDLE;
                    end
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        w_st_nx = 8'd0;
        case (st_addr)
            ST_SEL_FLAGS: w_st_nx = {r_err_cmd, r_err_win, 2'b00, 2'(r_state), w_busy, w_deliver};
            ST_SEL_COUNT: w_st_nx = r_cnt[7:0];
            ST_SEL_ADDR:  w_st_nx = 8'(r_addr);
            default:      w_st_nx = 8'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_addr    <= '0;
            r_cnt     <= '0;
            r_hit     <= 1'b0;
            r_err_cmd <= 1'b0;
            r_err_win <= 1'b0;
            r_st      <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_addr    <= w_addr_nx;
            r_cnt     <= w_cnt_nx;
            r_hit     <= w_hit_nx;
            r_err_cmd <= r_err_cmd | w_err_cmd_set;
            r_err_win <= r_err_win | w_err_win_set;
            r_st      <= w_st_nx;
        end
    end

    assign ddram_busy       = w_busy;
    assign ddram_dout_ready = w_deliver;
    assign ddram_dout       = (w_deliver && r_hit) ? w_data : 64'd0;
    assign st_dout          = r_st;

endmodule

// File: tb/tb_jtframe_ddram_bram.sv
// tb/tb_jtframe_ddram_bram.sv - self-checking bench for jtframe_ddram_bram against an array memory model
module tb_jtframe_ddram_bram;

    localparam int          AW    = 12;
    localparam int          DEPTH = 1 << AW;
    localparam logic [28:0] BASEA = 29'h0600_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        ddram_busy;
    logic [7:0]  ddram_burstcnt;
    logic [28:0] ddram_addr;
    logic        ddram_rd;
    logic        ddram_we;
    logic [63:0] ddram_din;
    logic [7:0]  ddram_be;
    logic [63:0] ddram_dout;
    logic        ddram_dout_ready;
    logic [7:0]  st_addr;
    logic [7:0]  st_dout;

    logic [63:0] model [DEPTH];
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    jtframe_ddram_bram #(.AW(AW), .BASE(4'd3), .STW(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .ddram_busy       (ddram_busy),
        .ddram_burstcnt   (ddram_burstcnt),
        .ddram_addr       (ddram_addr),
        .ddram_rd         (ddram_rd),
        .ddram_we         (ddram_we),
        .ddram_din        (ddram_din),
        .ddram_be         (ddram_be),
        .ddram_dout       (ddram_dout),
        .ddram_dout_ready (ddram_dout_ready),
        .st_addr          (st_addr),
        .st_dout          (st_dout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit in_window(input logic [28:0] a);
        return (a[28:25] == 4'd3) && (a[24:AW] == '0);
    endfunction

    function automatic int idx_of(input logic [28:0] a, input int i);
        return (int'(a[AW-1:0]) + i) % DEPTH;
    endfunction

    function automatic logic [63:0] exp_word(input logic [28:0] a, input int i);
        return in_window(a) ? model[idx_of(a, i)] : 64'd0;
    endfunction

    task automatic write_burst(input logic [28:0] a, input int n, input logic [7:0] be,
                               input logic [63:0] d[$], input bit with_rd);
        ddram_addr     = a;
        ddram_burstcnt = 8'(n);
        ddram_be       = be;
        ddram_we       = 1'b1;
        ddram_rd       = with_rd;
        for (int i = 0; i < n; i++) begin
            ddram_din = d[i];
            if (in_window(a)) begin
                for (int b = 0; b < 8; b++) begin
                    if (be[b]) model[idx_of(a, i)][b*8 +: 8] = d[i][b*8 +: 8];
                end
            end
            tick();
            ddram_rd = 1'b0;
        end
        ddram_we = 1'b0;
    endtask

    task automatic read_burst(input logic [28:0] a, input int n, input string tag);
        int got = 0;
        int cyc = 1;
        int first = 0;
        int last = 0;
        ddram_addr     = a;
        ddram_burstcnt = 8'(n);
        ddram_rd       = 1'b1;
        tick();
        ddram_rd = 1'b0;
        while (got < n && cyc < n + 20) begin
            if (ddram_dout_ready) begin
                if (got == 0) first = cyc;
                last = cyc;
                chk({tag, "_data"}, ddram_dout, exp_word(a, got));
                got++;
            end
            tick();
            cyc++;
        end
        chk({tag, "_beats"}, 64'(got), 64'(n));
        chk({tag, "_latency"}, 64'(first), 64'd2);
        chk({tag, "_span"}, 64'(last - first + 1), 64'(n));
    endtask

    task automatic check_st(input logic [7:0] sel, input logic [7:0] exp, input string tag);
        st_addr = sel;
        tick();
        chk(tag, 64'(st_dout), 64'(exp));
        st_addr = 8'd0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] d[$];
        logic [28:0] a;
        int          n;
        int          got;
        int          cyc;
        int          hold;
        logic [7:0]  be;

        rst = 1'b1; ddram_burstcnt = '0; ddram_addr = '0; ddram_rd = 1'b0; ddram_we = 1'b0;
        ddram_din = '0; ddram_be = '0; st_addr = 8'd0;
        repeat (3) tick();
        chk("rst_busy", 64'(ddram_busy), 64'd0);
        chk("rst_dout", ddram_dout, 64'd0);
        chk("rst_dout_ready", 64'(ddram_dout_ready), 64'd0);
        chk("rst_st_dout", 64'(st_dout), 64'd0);
        rst = 1'b0;
        tick();

        // Fill the whole BRAM so every later read has a known expected value.
        for (int k = 0; k < DEPTH / 256; k++) begin
            d.delete();
            for (int i = 0; i < 256; i++) d.push_back({$urandom, $urandom});
            write_burst(BASEA + 29'(k * 256), 256, 8'hFF, d, 1'b0);
        end

        d = '{64'd1, 64'd2, 64'd3, 64'd4};
        write_burst(BASEA, 4, 8'hFF, d, 1'b0);
        read_burst(BASEA, 4, "wr4");
        check_st(8'd1, 8'd0, "st_count");
        check_st(8'd2, 8'h04, "st_addr");

        d = '{64'hFFFF_FFFF_FFFF_FFFF};
        write_burst(BASEA + 29'h40, 1, 8'hFF, d, 1'b0);
        d = '{64'h1122_3344_5566_7788};
        write_burst(BASEA + 29'h40, 1, 8'h0F, d, 1'b0);
        read_burst(BASEA + 29'h40, 1, "byte_en");

        d.delete();
        for (int i = 0; i < 4; i++) d.push_back({$urandom, $urandom});
        write_burst(BASEA + 29'(DEPTH - 2), 4, 8'hFF, d, 1'b0);
        read_burst(BASEA + 29'(DEPTH - 2), 4, "wrap");
        check_st(8'd0, 8'h00, "wrap_flags");

        read_burst(BASEA + 29'd512, 256, "rd256");

        ddram_addr = BASEA + 29'd1024; ddram_burstcnt = 8'd128; ddram_rd = 1'b1;
        tick();
        ddram_rd = 1'b0;
        got = 0; cyc = 0; hold = 0;
        while (got < 512 && cyc < 1000) begin
            if (ddram_dout_ready) begin
                chk("chain_data", ddram_dout, model[1024 + got]);
                got++;
                if (got % 128 == 0 && got < 512) begin
                    ddram_addr = BASEA + 29'(1024 + got);
                    ddram_rd   = 1'b1;
                    hold       = 2;
                end
            end
            tick();
            cyc++;
            if (hold > 0) begin
                hold--;
                if (hold == 0) ddram_rd = 1'b0;
            end
        end
        chk("chain_beats", 64'(got), 64'd512);
        check_st(8'd0, 8'h00, "chain_flags");

        repeat (6) begin
            a  = BASEA + 29'($urandom_range(0, DEPTH - 1));
            n  = $urandom_range(1, 24);
            be = 8'($urandom);
            d.delete();
            for (int i = 0; i < n; i++) d.push_back({$urandom, $urandom});
            write_burst(a, n, be, d, 1'b0);
            read_burst(a, n, "rand");
        end

        d = '{{$urandom, $urandom}};
        write_burst(BASEA + 29'h10, 1, 8'hFF, d, 1'b0);
        a = {4'd2, 13'd0, 12'h010};
        d = '{{$urandom, $urandom}};
        write_burst(a, 1, 8'hFF, d, 1'b0);
        read_burst(a, 2, "miss");
        check_st(8'd0, 8'h40, "miss_flags");
        read_burst(BASEA + 29'h10, 1, "alias");
        read_burst(BASEA | 29'h1010, 1, "miss_mid");

        d = '{{$urandom, $urandom}};
        write_burst(BASEA + 29'h20, 1, 8'hFF, d, 1'b1);
        tick();
        chk("collide_no_read", 64'(ddram_dout_ready), 64'd0);
        check_st(8'd0, 8'hC0, "collide_flags");
        read_burst(BASEA + 29'h20, 1, "collide_data");

        ddram_addr = BASEA + 29'd1024; ddram_burstcnt = 8'd16; ddram_rd = 1'b1;
        tick();
        ddram_rd = 1'b0;
        got = 0; cyc = 0;
        while (got < 3 && cyc < 20) begin
            if (ddram_dout_ready) got++;
            if (got < 3) begin
                tick();
                cyc++;
            end
        end
        chk("rst_mid_beats", 64'(got), 64'd3);
        rst = 1'b1;
        tick();
        chk("rst_mid_ready", 64'(ddram_dout_ready), 64'd0);
        chk("rst_mid_dout", ddram_dout, 64'd0);
        chk("rst_mid_st", 64'(st_dout), 64'd0);
        rst = 1'b0;
        tick();
        check_st(8'd0, 8'h00, "rst_mid_idle");
        read_burst(BASEA + 29'd2000, 8, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
